// File: rtl/ula_cmp_arbiter_pkg.sv
// Shared constants for the ULA comparator arbiter: flag bit map, flag width and FSM encodings.
package ula_cmp_arbiter_pkg;

  localparam int unsigned FLAG_W = 6;

  // Bit positions inside the 6-bit comparator flag vector (unsigned compare)
  localparam int unsigned FLAG_GT = 0;
  localparam int unsigned FLAG_LT = 1;
  localparam int unsigned FLAG_GE = 2;
  localparam int unsigned FLAG_LE = 3;
  localparam int unsigned FLAG_EQ = 4;
  localparam int unsigned FLAG_NE = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/ula_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from i_ptr, wrapping.
module ula_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int unsigned      w_pos;
  logic [IDX_W-1:0] w_pos_idx;

  always_comb begin
    o_onehot  = '0;
    o_idx     = '0;
    o_valid   = 1'b0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_pos = 32'(i_ptr) + off;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      w_pos_idx = IDX_W'(w_pos);
      if (!o_valid && i_req[w_pos_idx]) begin
        o_valid             = 1'b1;
        o_onehot[w_pos_idx] = 1'b1;
        o_idx               = w_pos_idx;
      end
    end
  end

endmodule

// File: rtl/ula_cmp_arbiter.sv
// Shares one tri-stated 8-bit comparator among N_REQ requesters: round-robin grant,
// operand latch, SETTLE-cycle enable window, flag capture and one-cycle done pulse.
module ula_cmp_arbiter
  import ula_cmp_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned W      = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_a_in,
  input  logic [N_REQ*W-1:0] i_b_in,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [FLAG_W-1:0]  o_flags,
  output logic               o_busy,
  output logic [W-1:0]       o_cmp_a,
  output logic [W-1:0]       o_cmp_b,
  output logic               o_cmp_en,
  input  logic [FLAG_W-1:0]  i_cmp_s
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic [FLAG_W-1:0]  r_flags;
  logic [W-1:0]       r_cmp_a;
  logic [W-1:0]       r_cmp_b;
  logic               r_cmp_en;

  logic [N_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic [W-1:0]       w_a_sel;
  logic [W-1:0]       w_b_sel;
  logic               w_settle_last;
  logic [IDX_W-1:0]   w_ptr_next;

  ula_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_a_sel = i_a_in[i*W +: W];
        w_b_sel = i_b_in[i*W +: W];
      end
    end
  end

  assign w_settle_last = (r_cnt == CNT_W'(SETTLE - 1));
  assign w_ptr_next    = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_flags  <= '0;
      r_cmp_a  <= '0;
      r_cmp_b  <= '0;
      r_cmp_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= '0;
          if (w_win_valid) begin
            r_gnt    <= w_win_oh;
            r_win    <= w_win_idx;
            r_cmp_a  <= w_a_sel;
            r_cmp_b  <= w_b_sel;
            r_cmp_en <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Capture only while the comparator is enabled, so its high-Z never lands in flags
          if (w_settle_last) begin
            r_flags  <= i_cmp_s;
            r_done   <= r_gnt;
            r_cmp_en <= 1'b0;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt    <= '0;
          r_done   <= '0;
          r_cmp_en <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt    = r_gnt;
  assign o_done   = r_done;
  assign o_flags  = r_flags;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_cmp_a  = r_cmp_a;
  assign o_cmp_b  = r_cmp_b;
  assign o_cmp_en = r_cmp_en;

endmodule
